// File: rtl/fetch_pkg.sv
// Types and constants for the instruction fetch unit.
//   fetch_entry_t : one fetch-buffer slot {pc, instr, filled}
//   FETCH_DEPTH   : default number of buffer entries
//   PTR_W         : pointer width (index plus wrap bit) for FETCH_DEPTH
`ifndef IFETCH_DEFINES_SV
`include "defines.sv"
`endif

package fetch_pkg;

    localparam int FETCH_DEPTH = 4;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int PTR_W = ptr_w(FETCH_DEPTH);

    typedef struct packed {
        logic [`DWORD_BITS-1:0] pc;
        logic [`WORD_BITS-1:0]  instr;
        logic                   filled;
    } fetch_entry_t;

endpackage

// File: rtl/defines.sv
// Global width macros shared by the fetch slice.
//   DWORD_BITS : PC / address width
//   WORD_BITS  : instruction word width
`ifndef IFETCH_DEFINES_SV
`define IFETCH_DEFINES_SV
`define DWORD_BITS 64
`define WORD_BITS 32
`endif

// File: rtl/ifetch_unit.sv
// Instruction fetch unit.
// Issues in-order instruction-memory reads at pc_in, advancing the PC on
// every accepted request. Responses are written into a small circular buffer
// in request order and handed to decode over valid/ready. A redirect flushes
// the buffer and arms a drop counter that swallows responses still in flight
// for the discarded requests.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   pc_in / pc_en            current PC in, advance/load strobe out
//   redirect                 branch resolved; PC loads its target this cycle
//   imem_req_valid/_addr/_ready   read request channel
//   imem_rsp_valid/_data     in-order read response (always accepted)
//   dec_valid/_instr/_pc/_ready   decode handoff of the head entry
`ifndef IFETCH_DEFINES_SV
`include "defines.sv"
`endif

module ifetch_unit
    import fetch_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [`DWORD_BITS-1:0] pc_in,
    output logic                   pc_en,
    input  logic                   redirect,
    output logic                   imem_req_valid,
    output logic [`DWORD_BITS-1:0] imem_req_addr,
    input  logic                   imem_req_ready,
    input  logic                   imem_rsp_valid,
    input  logic [`WORD_BITS-1:0]  imem_rsp_data,
    output logic                   dec_valid,
    output logic [`WORD_BITS-1:0]  dec_instr,
    output logic [`DWORD_BITS-1:0] dec_pc,
    input  logic                   dec_ready
);

    localparam int PW    = ptr_w(DEPTH);
    localparam int IDX_W = PW - 1;
    localparam int CW    = $clog2(DEPTH + 1);

    // Buffer storage; only the filled flags need a reset value.
    logic [`DWORD_BITS-1:0] pc_q    [DEPTH];
    logic [`WORD_BITS-1:0]  instr_q [DEPTH];
    logic [DEPTH-1:0]       filled_q;

    logic [PW-1:0] head_q, tail_q, fill_q;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;

    logic [PW-1:0]    count, unfilled;
    logic [IDX_W-1:0] head_idx, tail_idx, fill_idx;
    logic             full, req_fire, rsp_take, pop;
    logic [PW:0]      drop_sum;
    fetch_entry_t     head_ent;

    assign head_idx = head_q[IDX_W-1:0];
    assign tail_idx = tail_q[IDX_W-1:0];
    assign fill_idx = fill_q[IDX_W-1:0];

    assign count    = tail_q - head_q;
    assign unfilled = tail_q - fill_q;
    // Full uses the registered count only: a pop in the same cycle does not
    // free a slot until the next cycle.
    assign full     = (count == PW'(DEPTH));

    assign imem_req_valid = !rst && !redirect && !full;
    assign imem_req_addr  = pc_in;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign pc_en          = !rst && (req_fire || redirect);

    assign head_ent  = '{pc: pc_q[head_idx], instr: instr_q[head_idx], filled: filled_q[head_idx]};
    assign dec_valid = !rst && head_ent.filled;
    assign dec_pc    = head_ent.pc;
    assign dec_instr = head_ent.instr;
    assign pop       = dec_valid && dec_ready && !redirect;

    // Responses are only written when no stale response is owed.
    assign rsp_take  = imem_rsp_valid && (drop_cnt_q == '0) && !redirect;

    // On redirect every allocated-but-unfilled request becomes stale; a
    // response arriving in the redirect cycle itself is already discarded,
    // so it is subtracted from the amount still owed.
    always_comb begin
        drop_sum   = (PW+1)'(drop_cnt_q) + (PW+1)'(unfilled) - (PW+1)'(imem_rsp_valid);
        drop_cnt_d = drop_cnt_q;
        if (redirect) begin
            drop_cnt_d = CW'(drop_sum);
        end else if (imem_rsp_valid && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            fill_q     <= '0;
            drop_cnt_q <= '0;
            filled_q   <= '0;
        end else if (redirect) begin
            head_q     <= '0;
            tail_q     <= '0;
            fill_q     <= '0;
            drop_cnt_q <= drop_cnt_d;
            filled_q   <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            if (req_fire) begin
                pc_q[tail_idx]     <= pc_in;
                filled_q[tail_idx] <= 1'b0;
                tail_q             <= tail_q + PW'(1);
            end
            if (rsp_take) begin
                instr_q[fill_idx]  <= imem_rsp_data;
                filled_q[fill_idx] <= 1'b1;
                fill_q             <= fill_q + PW'(1);
            end
            // Clearing on pop keeps a stale flag from a previous lap from
            // presenting as valid once head wraps onto it.
            if (pop) begin
                filled_q[head_idx] <= 1'b0;
                head_q             <= head_q + PW'(1);
            end
        end
    end

    // A live response must have an allocated, unfilled entry to land in.
    a_rsp_has_slot: assert property (@(posedge clk) disable iff (rst)
        (imem_rsp_valid && (drop_cnt_q == '0)) |-> (fill_q != tail_q));

    // Stale responses owed can never exceed the buffer depth.
    a_drop_bound: assert property (@(posedge clk) disable iff (rst)
        redirect |-> (drop_sum <= (PW+1)'(DEPTH)));

endmodule

// File: tb/tb_ifetch_unit.sv
`ifndef IFETCH_DEFINES_SV
`include "defines.sv"
`endif

module tb_ifetch_unit;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [`DWORD_BITS-1:0] pc_in = '0;
    logic                   pc_en;
    logic                   redirect;
    logic                   imem_req_valid;
    logic [`DWORD_BITS-1:0] imem_req_addr;
    logic                   imem_req_ready;
    logic                   imem_rsp_valid = 1'b0;
    logic [`WORD_BITS-1:0]  imem_rsp_data = '0;
    logic                   dec_valid;
    logic [`WORD_BITS-1:0]  dec_instr;
    logic [`DWORD_BITS-1:0] dec_pc;
    logic                   dec_ready;

    ifetch_unit #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .pc_en(pc_en), .redirect(redirect),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .dec_valid(dec_valid), .dec_instr(dec_instr),
        .dec_pc(dec_pc), .dec_ready(dec_ready)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Memory / PC model state
    logic [63:0] pend[$];
    logic [63:0] pc_nxt = '0;
    logic [63:0] tgt = '0;
    logic        mem_hold = 1'b0;
    int          mem_rel = 0;

    function automatic logic [31:0] data_of(input logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_0000;
    endfunction

    // Per cycle after negedge: +0 PC update, +1 response drive,
    // +2 stimulus, +3 checks, +4 handshake sampling.
    always begin
        logic [63:0] a;
        @(negedge clk);
        pc_in = pc_nxt;
        #1;
        if (pend.size() > 0 && (!mem_hold || mem_rel > 0)) begin
            a = pend.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = data_of(a);
            if (mem_hold) mem_rel--;
        end else begin
            imem_rsp_valid = 1'b0;
        end
        #3;
        if (imem_req_valid && imem_req_ready) pend.push_back(imem_req_addr);
        if (rst) begin
            pend.delete();
            pc_nxt = '0;
        end else if (pc_en) begin
            pc_nxt = redirect ? tgt : pc_in + 64'd4;
        end
    end

    task automatic cyc();
        @(negedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int hs;
        rst = 1'b1; redirect = 1'b0; imem_req_ready = 1'b1; dec_ready = 1'b0;

        // 1: reset
        cyc(); #1;
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_pc_en", pc_en, 0);
        chk("rst_dec_valid", dec_valid, 0);
        cyc();
        cyc(); rst = 1'b0; dec_ready = 1'b1; #1;
        chk("post_rst_req_valid", imem_req_valid, 1);
        chk("post_rst_addr", imem_req_addr, 64'h0);
        chk("post_rst_dec_valid", dec_valid, 0);

        // 2: streaming, latency 1
        cyc(); #1;
        chk("stream_lat_dec_valid", dec_valid, 0);
        chk("stream_addr1", imem_req_addr, 64'h4);
        cyc(); #1;
        chk("stream_first_valid", dec_valid, 1);
        chk("stream_pc0", dec_pc, 64'h0);
        chk("stream_instr0", dec_instr, data_of(64'h0));
        cyc(); #1;
        chk("stream_pc1", dec_pc, 64'h4);
        chk("stream_instr1", dec_instr, data_of(64'h4));
        cyc(); #1;
        chk("stream_pc2", dec_pc, 64'h8);

        // 3: fill with decode stalled
        cyc(); rst = 1'b1; dec_ready = 1'b0;
        cyc(); rst = 1'b0;
        hs = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (imem_req_valid && imem_req_ready) hs++;
            cyc();
        end
        #1;
        chk("fill_handshakes", hs, 4);
        chk("fill_req_valid", imem_req_valid, 0);
        chk("fill_pc_en", pc_en, 0);
        chk("fill_dec_pc", dec_pc, 64'h0);
        cyc(); dec_ready = 1'b1; #1;
        chk("full_pop_no_alloc", imem_req_valid, 0);
        cyc(); dec_ready = 1'b0; #1;
        chk("after_pop_req", imem_req_valid, 1);
        chk("after_pop_addr", imem_req_addr, 64'h10);
        chk("after_pop_dec_pc", dec_pc, 64'h4);
        cyc(); #1;
        chk("after_pop_one_only", imem_req_valid, 0);

        // 4: redirect with 3 unfilled
        cyc(); rst = 1'b1; mem_hold = 1'b1;
        cyc(); rst = 1'b0;
        cyc();
        cyc();
        cyc(); redirect = 1'b1; tgt = 64'h100; mem_hold = 1'b0; #1;
        chk("redir_pc_en", pc_en, 1);
        chk("redir_req_valid", imem_req_valid, 0);
        cyc(); redirect = 1'b0; #1;
        chk("redir_resume_addr", imem_req_addr, 64'h100);
        chk("redir_resume_valid", imem_req_valid, 1);
        cyc(); #1;
        chk("redir_drop_valid_a", dec_valid, 0);
        cyc();
        cyc(); #1;
        chk("redir_drop_valid_b", dec_valid, 0);
        cyc(); #1;
        chk("redir_first_valid", dec_valid, 1);
        chk("redir_first_pc", dec_pc, 64'h100);
        chk("redir_first_instr", dec_instr, data_of(64'h100));
        cyc(); dec_ready = 1'b1; #1;
        chk("redir_head_hold", dec_pc, 64'h100);
        cyc(); dec_ready = 1'b0; #1;
        chk("redir_second_pc", dec_pc, 64'h104);

        // 5: redirect coincident with a response, 2 unfilled
        cyc(); rst = 1'b1; mem_hold = 1'b1;
        cyc(); rst = 1'b0;
        cyc(); mem_rel = 1;
        cyc(); redirect = 1'b1; tgt = 64'h200; mem_hold = 1'b0; #1;
        chk("co_redir_pc_en", pc_en, 1);
        chk("co_redir_req_valid", imem_req_valid, 0);
        cyc(); redirect = 1'b0; #1;
        chk("co_resume_addr", imem_req_addr, 64'h200);
        cyc(); #1;
        chk("co_drop_valid", dec_valid, 0);
        cyc(); #1;
        chk("co_first_valid", dec_valid, 1);
        chk("co_first_pc", dec_pc, 64'h200);
        chk("co_first_instr", dec_instr, data_of(64'h200));

        // 6: reset with a full buffer
        cyc();
        cyc();
        cyc(); #1;
        chk("full_before_rst_req", imem_req_valid, 0);
        chk("full_before_rst_dec", dec_valid, 1);
        cyc(); rst = 1'b1; #1;
        chk("mid_rst_dec_valid", dec_valid, 0);
        chk("mid_rst_req_valid", imem_req_valid, 0);
        chk("mid_rst_pc_en", pc_en, 0);
        cyc(); rst = 1'b0; #1;
        chk("restart_dec_valid", dec_valid, 0);
        chk("restart_req_valid", imem_req_valid, 1);
        chk("restart_addr", imem_req_addr, 64'h0);
        cyc(); #1;
        chk("restart_lat", dec_valid, 0);
        cyc(); #1;
        chk("restart_first_valid", dec_valid, 1);
        chk("restart_first_pc", dec_pc, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
